// File: rtl/udp_rx_pkt_fifo.sv
// Store-and-forward buffer for the UDP receive payload: packets are held whole,
// committed or dropped on their end-of-packet pulse, and replayed on a valid/ready stream.
module udp_rx_pkt_fifo #(
  parameter int ADDR_W     = 9,
  parameter int LEN_ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_en,
  input  logic [31:0]       rec_data,
  input  logic              rec_pkt_done,
  input  logic [15:0]       rec_byte_num,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic [3:0]        m_keep,
  output logic              m_last,
  output logic [ADDR_W:0]   fifo_level,
  output logic [15:0]       pkt_drop_cnt
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int LEN_DEPTH = 1 << LEN_ADDR_W;
  localparam logic [ADDR_W:0]     RAM_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_ADDR_W:0] LEN_FULL = {1'b1, {LEN_ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} rd_state_t;

  logic [31:0] ram [DEPTH];
  logic [15:0] len_mem [LEN_DEPTH];

  logic [ADDR_W:0]     wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_W:0]     wr_ptr_inc, wr_ptr_n, rd_ptr_n, used;
  logic [LEN_ADDR_W:0] len_wr, len_rd;
  logic [15:0]         in_words, in_words_inc, exp_words;
  logic                drop_flag;
  logic                ram_full, len_full, len_empty;
  logic                wr_accept, pkt_bad, pkt_commit, pkt_drop;

  rd_state_t           state, state_nxt;
  logic                len_pop, xfer;
  logic [ADDR_W-1:0]   ram_raddr;
  logic [31:0]         rd_word_p1;
  logic [15:0]         len_head, rd_bytes, rd_words, rem_words;

  function automatic logic [15:0] ceil_words(input logic [15:0] bytes);
    return {2'b00, bytes[15:2]} + {15'd0, |bytes[1:0]};
  endfunction

  function automatic logic [3:0] last_keep(input logic [1:0] tail);
    case (tail)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      2'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Write side: accept, then judge the packet including any same-cycle word
  always_comb begin
    used         = wr_ptr - rd_ptr;
    ram_full     = (used == RAM_FULL);
    len_full     = ((len_wr - len_rd) == LEN_FULL);
    len_empty    = (len_wr == len_rd);
    wr_accept    = rec_en && !ram_full && !drop_flag;
    wr_ptr_inc   = wr_ptr + {{ADDR_W{1'b0}}, wr_accept};
    in_words_inc = in_words + {15'd0, wr_accept};
    exp_words    = ceil_words(rec_byte_num);
    pkt_bad      = drop_flag || (rec_en && !wr_accept) || len_full ||
                   (rec_byte_num == 16'd0) || (in_words_inc != exp_words);
    pkt_commit   = rec_pkt_done && !pkt_bad;
    pkt_drop     = rec_pkt_done && pkt_bad;
    wr_ptr_n     = pkt_drop ? commit_ptr : wr_ptr_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      in_words     <= '0;
      drop_flag    <= 1'b0;
      pkt_drop_cnt <= '0;
      len_wr       <= '0;
      len_rd       <= '0;
      fifo_level   <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      fifo_level <= wr_ptr_n - rd_ptr_n;
      len_wr     <= len_wr + {{LEN_ADDR_W{1'b0}}, pkt_commit};
      len_rd     <= len_rd + {{LEN_ADDR_W{1'b0}}, len_pop};
      if (pkt_commit)
        commit_ptr <= wr_ptr_inc;
      if (pkt_drop)
        pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
      if (rec_pkt_done) begin
        in_words  <= '0;
        drop_flag <= 1'b0;
      end else begin
        in_words  <= in_words_inc;
        drop_flag <= drop_flag || (rec_en && !wr_accept);
      end
    end
  end

  // Storage and the registered RAM read port
  always_ff @(posedge clk) begin
    if (wr_accept)
      ram[wr_ptr[ADDR_W-1:0]] <= rec_data;
    if (pkt_commit)
      len_mem[len_wr[LEN_ADDR_W-1:0]] <= rec_byte_num;
    rd_word_p1 <= ram[ram_raddr];
  end

  assign len_head = len_mem[len_rd[LEN_ADDR_W-1:0]];
  assign rd_words = ceil_words(rd_bytes);

  // Read side: the RAM is read one word ahead so back-to-back transfers have no bubble
  always_comb begin
    state_nxt = state;
    len_pop   = 1'b0;
    xfer      = 1'b0;
    ram_raddr = rd_ptr[ADDR_W-1:0];
    case (state)
      IDLE: begin
        if (!len_empty) begin
          len_pop   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ram_raddr = rd_ptr[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};
        state_nxt = STREAM;
      end
      STREAM: begin
        xfer      = m_valid && m_ready;
        ram_raddr = rd_ptr[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1}
                    + {{(ADDR_W-1){1'b0}}, xfer};
        if (xfer && m_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    rd_ptr_n = rd_ptr + {{ADDR_W{1'b0}}, xfer};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      rd_bytes  <= '0;
      rem_words <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_n;
      case (state)
        IDLE: begin
          if (len_pop)
            rd_bytes <= len_head;
        end
        LOAD: begin
          m_valid   <= 1'b1;
          m_data    <= rd_word_p1;
          m_last    <= (rd_words == 16'd1);
          m_keep    <= (rd_words == 16'd1) ? last_keep(rd_bytes[1:0]) : 4'b1111;
          rem_words <= rd_words - 16'd1;
        end
        STREAM: begin
          if (xfer) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              m_keep  <= '0;
            end else begin
              m_data    <= rd_word_p1;
              m_last    <= (rem_words == 16'd1);
              m_keep    <= (rem_words == 16'd1) ? last_keep(rd_bytes[1:0]) : 4'b1111;
              rem_words <= rem_words - 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_pkt_fifo.sv
// Bench for udp_rx_pkt_fifo (16-word RAM): directed scenarios plus randomized packets
// checked against a byte-level reference model.
module tb_udp_rx_pkt_fifo;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rec_en = 1'b0;
  logic [31:0]       rec_data = '0;
  logic              rec_pkt_done = 1'b0;
  logic [15:0]       rec_byte_num = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [31:0]       m_data;
  logic [3:0]        m_keep;
  logic              m_last;
  logic [ADDR_W:0]   fifo_level;
  logic [15:0]       pkt_drop_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       cap_q[$];
  beat_t       exp_q[$];
  logic [31:0] tx_q[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_drops = 0;

  udp_rx_pkt_fifo #(.ADDR_W(ADDR_W), .LEN_ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rec_en(rec_en), .rec_data(rec_data), .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .fifo_level(fifo_level), .pkt_drop_cnt(pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  // A beat seen valid&ready at the falling edge transfers on the next rising edge
  always @(negedge clk)
    if (rst_n && m_valid && m_ready)
      cap_q.push_back(beat_t'({m_data, m_keep, m_last}));

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random payload, bytes at or beyond nbytes forced to zero
  task automatic build_pkt(input int nwords, input int nbytes);
    logic [31:0] w;
    tx_q.delete();
    for (int i = 0; i < nwords; i++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++)
        if (4 * i + j >= nbytes) w[31 - 8 * j -: 8] = 8'h00;
      tx_q.push_back(w);
    end
  endtask

  // Reference: every byte position below nbytes is enabled; the final word is last
  task automatic model_expect(input int nbytes);
    beat_t b;
    for (int i = 0; i < tx_q.size(); i++) begin
      b.d = tx_q[i];
      for (int j = 0; j < 4; j++) b.k[3 - j] = (4 * i + j < nbytes);
      b.l = (i == tx_q.size() - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic bit model_accept(input int nwords, input int nbytes, input int free_words);
    return (nbytes > 0) && (nwords <= free_words) &&
           (nwords * 4 >= nbytes) && (nwords * 4 < nbytes + 4);
  endfunction

  task automatic send_pkt(input int nbytes, input bit same_cycle);
    for (int i = 0; i < tx_q.size(); i++) begin
      @(posedge clk); #1;
      rec_en       = 1'b1;
      rec_data     = tx_q[i];
      rec_byte_num = 16'(nbytes);
      rec_pkt_done = same_cycle && (i == tx_q.size() - 1);
    end
    if (!same_cycle) begin
      @(posedge clk); #1;
      rec_en       = 1'b0;
      rec_data     = '0;
      rec_pkt_done = 1'b1;
      rec_byte_num = 16'(nbytes);
    end
    @(posedge clk); #1;
    rec_en       = 1'b0;
    rec_pkt_done = 1'b0;
    rec_data     = '0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget && cap_q.size() < n; c++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_valid, m_last, m_keep} !== 6'd0) begin
      failures++;
      $display("FAIL reset_ctrl: valid/last/keep=%b required 0", {m_valid, m_last, m_keep});
    end
    checks++;
    if (m_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: m_data=%h required 0", m_data);
    end
    checks++;
    if (fifo_level !== 5'd0 || pkt_drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts: level=%0d drops=%0d required 0/0", fifo_level, pkt_drop_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_ten_byte();
    m_ready = 1'b0;
    tx_q.delete();
    tx_q.push_back(32'h01020304);
    tx_q.push_back(32'h05060708);
    tx_q.push_back(32'h090A0000);
    exp_q.push_back(beat_t'({32'h01020304, 4'b1111, 1'b0}));
    exp_q.push_back(beat_t'({32'h05060708, 4'b1111, 1'b0}));
    exp_q.push_back(beat_t'({32'h090A0000, 4'b1100, 1'b1}));
    send_pkt(10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL ten_latency_early: m_valid=%b one cycle after done, required 0", m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL ten_latency: m_valid=%b two cycles after done, required 1", m_valid);
    end
    checks++;
    if (fifo_level !== 5'd3) begin
      failures++;
      $display("FAIL ten_level: fifo_level=%0d required 3", fifo_level);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_beats(3, 50);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ten_count: beats=%0d required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ten_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL ten_drain: fifo_level=%0d required 0", fifo_level);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    m_ready = 1'b1;
    build_pkt(1, 4);
    model_expect(4);
    send_pkt(4, 1'b1);
    build_pkt(2, 8);
    model_expect(8);
    send_pkt(8, 1'b0);
    wait_beats(3, 60);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: beats=%0d required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt_drop_cnt !== 16'(exp_drops)) begin
      failures++;
      $display("FAIL b2b_drops: pkt_drop_cnt=%0d required %0d", pkt_drop_cnt, exp_drops);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    m_ready = 1'b0;
    build_pkt(20, 80);
    send_pkt(80, 1'b0);
    exp_drops++;
    repeat (3) @(negedge clk);
    checks++;
    if (pkt_drop_cnt !== 16'(exp_drops)) begin
      failures++;
      $display("FAIL ovf_drops: pkt_drop_cnt=%0d required %0d", pkt_drop_cnt, exp_drops);
    end
    checks++;
    if (fifo_level !== 5'd0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_state: level=%0d valid=%b required 0/0", fifo_level, m_valid);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    build_pkt(2, 8);
    model_expect(8);
    send_pkt(8, 1'b0);
    wait_beats(2, 60);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ovf_next_count: beats=%0d required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ovf_next_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic test_mismatch();
    bit seen;
    @(posedge clk); #1;
    m_ready = 1'b1;
    build_pkt(3, 16);
    send_pkt(16, 1'b0);
    exp_drops++;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mismatch_valid: m_valid observed 1, required never");
    end
    checks++;
    if (pkt_drop_cnt !== 16'(exp_drops) || fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL mismatch_counts: drops=%0d level=%0d required %0d/0",
               pkt_drop_cnt, fifo_level, exp_drops);
    end
    cap_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t held;
    bit    stalled;
    @(posedge clk); #1;
    m_ready = 1'b0;
    build_pkt(5, 18);
    model_expect(18);
    send_pkt(18, 1'b0);
    stalled = 1'b0;
    for (int c = 0; c < 100 && cap_q.size() < 5; c++) begin
      @(posedge clk); #1;
      m_ready = c[0];
      @(negedge clk);
      if (stalled && m_valid) begin
        checks++;
        if (beat_t'({m_data, m_keep, m_last}) !== held) begin
          failures++;
          $display("FAIL bp_stable: got %h held %h", beat_t'({m_data, m_keep, m_last}), held);
        end
      end
      stalled = m_valid && !m_ready;
      held    = beat_t'({m_data, m_keep, m_last});
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count: beats=%0d required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    m_ready = 1'b1;
    build_pkt(6, 24);
    send_pkt(24, 1'b0);
    for (int c = 0; c < 40 && cap_q.size() < 2; c++) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_active: m_valid=%b before reset, required 1", m_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, m_keep} !== 6'd0 || m_data !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: valid=%b last=%b keep=%b data=%h required all 0",
               m_valid, m_last, m_keep, m_data);
    end
    checks++;
    if (fifo_level !== 5'd0 || pkt_drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_counts: level=%0d drops=%0d required 0/0", fifo_level, pkt_drop_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_drops = 0;
    cap_q.delete();
    exp_q.delete();
    build_pkt(3, 11);
    model_expect(11);
    send_pkt(11, 1'b1);
    wait_beats(3, 60);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rstmid_next_count: beats=%0d required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rstmid_next_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int n, nbytes, kind;
    bit same, acc;
    for (int p = 0; p < 30; p++) begin
      n      = $urandom_range(1, 20);
      kind   = $urandom_range(0, 9);
      nbytes = 4 * (n - 1) + $urandom_range(1, 4);
      if (kind == 0) nbytes = nbytes + 4 * $urandom_range(1, 3);
      if (kind == 1) nbytes = 0;
      if (kind == 2 && n > 1) nbytes = nbytes - 4;
      same = 1'($urandom_range(0, 1));
      build_pkt(n, nbytes);
      acc = model_accept(n, nbytes, DEPTH);
      if (acc) model_expect(nbytes);
      else exp_drops++;
      send_pkt(nbytes, same);
      for (int c = 0; c < 200 && !(cap_q.size() == exp_q.size() && fifo_level == 5'd0); c++) begin
        @(posedge clk); #1;
        m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (cap_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count: beats=%0d required %0d (n=%0d bytes=%0d)",
                 p, cap_q.size(), exp_q.size(), n, nbytes);
      end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        checks++;
        if (cap_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_beat%0d: got %h required %h", p, i, cap_q[i], exp_q[i]);
        end
      end
      checks++;
      if (pkt_drop_cnt !== 16'(exp_drops) || fifo_level !== 5'd0) begin
        failures++;
        $display("FAIL rand%0d_counts: drops=%0d level=%0d required %0d/0",
                 p, pkt_drop_cnt, fifo_level, exp_drops);
      end
      cap_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_ten_byte();
    test_back_to_back();
    test_overflow();
    test_mismatch();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_rx_pkt_fifo.md
Name: udp_rx_pkt_fifo

Overview:
- Consumes the UDP payload word stream from the Ethernet receive path (rec_en / rec_data / rec_pkt_done / rec_byte_num) in the eth_clk domain.
- Buffers each packet whole, and only on packet completion commits it or discards it.
- Replays committed packets on a valid/ready stream with last and byte-keep flags, for the downstream DMA/processing logic.
- Drops any packet that does not fit, or whose word count disagrees with its byte count, and counts it.

Parameters:
- ADDR_W, 9, data RAM address width; depth 2^ADDR_W 32-bit words.
- LEN_ADDR_W, 4, length-FIFO address width; holds up to 2^LEN_ADDR_W committed packets.

Ports:
- clk  input  1  eth_clk; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rec_en  input  1  one payload word valid this cycle.
- rec_data  input  32  payload word; first byte in [31:24]; partial final word is zero-padded in the low bytes.
- rec_pkt_done  input  1  single-cycle end-of-packet pulse.
- rec_byte_num  input  16  payload byte count; sampled only when rec_pkt_done=1.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  32  output word, same byte order as rec_data.
- m_keep  output  4  byte enables, bit3 = [31:24].
- m_last  output  1  final word of the packet.
- fifo_level  output  ADDR_W+1  words held (committed + in-progress).
- pkt_drop_cnt  output  16  saturating count of dropped packets.

Behaviour:
- Reset: all outputs 0; all pointers, the length FIFO, the word counter, the drop flag and pkt_drop_cnt are cleared.
- Reset asserted mid-packet or mid-readout abandons all content. The input stream after reset release is accepted from the next rec_en.
- Pointers are ADDR_W+1 bits (wrap bit): wr_ptr, commit_ptr, rd_ptr. The RAM is full when wr_ptr - rd_ptr == 2^ADDR_W.
- Write path, on rec_en:
  - If the RAM is not full and drop_flag=0: write at wr_ptr, then increment wr_ptr and the 16-bit in_words counter.
  - Otherwise set drop_flag and discard the word.
- Commit, on rec_pkt_done (evaluated after any same-cycle rec_en word):
  - exp_words = ceil(rec_byte_num/4).
  - Drop if any of: drop_flag=1; length FIFO full; rec_byte_num==0; in_words != exp_words, where in_words includes any word accepted in the same cycle.
  - On drop: wr_ptr <= commit_ptr, pkt_drop_cnt++ (saturates at 16'hFFFF).
  - Otherwise: push rec_byte_num to the length FIFO and set commit_ptr <= new wr_ptr.
  - In both cases, clear in_words and drop_flag.
- rec_en with no subsequent rec_pkt_done stays uncommitted indefinitely and is never output.
- Read FSM states: IDLE, LOAD, STREAM.
  - IDLE -> LOAD when the length FIFO is non-empty. Pop the length into rd_bytes, compute rd_words = ceil(rd_bytes/4), issue the RAM read at rd_ptr.
  - LOAD -> STREAM after one cycle (synchronous RAM read latency). The word is placed in the output register and m_valid=1.
  - STREAM: a transfer occurs when m_valid & m_ready; rd_ptr then advances.
    - If the word was not last: prefetch the next word so that m_valid remains 1 with no bubble.
    - On the last-word transfer: m_valid <= 0 and return to IDLE.
- m_last=1 only on word rd_words-1.
- m_keep=4'b1111 except on the last word, where it depends on rd_bytes mod 4: 0 -> 1111, 1 -> 1000, 2 -> 1100, 3 -> 1110.
- While m_valid=1 and m_ready=0, m_data, m_keep and m_last hold stable.
- Latency: the first m_valid is 2 cycles after the committing rec_pkt_done edge (IDLE->LOAD->STREAM).
- Space reclaimed by reads is visible to the write path the cycle after rd_ptr advances.
- Simultaneous write at full and read freeing space in the same cycle: the write is still treated as full and the word is dropped. This is conservative.
- fifo_level = wr_ptr - rd_ptr, registered.

Test Plan:
- 10-byte packet: words 0x01020304, 0x05060708, 0x090A0000; rec_pkt_done with byte_num=10 -> 3 output words, m_keep 1111/1111/1100, m_last on word 3, first m_valid 2 cycles after done.
- Back-to-back packets of 4 and 8 bytes with m_ready=1 -> 1 word then 2 words. Last word of each has keep 1111 and m_last=1. pkt_drop_cnt=0.
- ADDR_W=4 (16 words), m_ready=0, 80-byte packet (20 words) -> packet dropped, pkt_drop_cnt=1, fifo_level returns to 0. A following 8-byte packet is delivered intact.
- Mismatch: 3 rec_en words then done with byte_num=16 -> dropped, no m_valid, pkt_drop_cnt increments.
- Backpressure: toggle m_ready every other cycle on a 5-word packet -> 5 transfers in order, data/keep/last stable while stalled.
- Assert rst_n=0 mid-stream of a 6-word output -> all outputs 0 immediately. After release, the next packet outputs correctly.
